// File: rtl/axi_slave_ram.sv
// AXI4 slave memory: word-addressed on-chip array with independent single-outstanding
// write (AW/W/B) and read (AR/R) channels; INCR and FIXED bursts, WRAP handled as INCR.
module axi_slave_ram #(
  parameter int unsigned AXI_DW    = 32,
  parameter int unsigned AXI_AW    = 32,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned ID_W      = 8
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic [ID_W-1:0]       s_axi_awid,
  input  logic [AXI_AW-1:0]     s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,

  input  logic [AXI_DW-1:0]     s_axi_wdata,
  input  logic [AXI_DW/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,

  output logic [ID_W-1:0]       s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,

  input  logic [ID_W-1:0]       s_axi_arid,
  input  logic [AXI_AW-1:0]     s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,

  output logic [ID_W-1:0]       s_axi_rid,
  output logic [AXI_DW-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int unsigned STRB_W     = AXI_DW / 8;
  localparam int unsigned AXSIZE_WTH = $clog2(STRB_W);
  localparam int unsigned IDX_W      = $clog2(MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [AXI_DW-1:0] mem [MEM_DEPTH];

  // Write channel state
  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   w_id_q,    w_id_d;
  logic [IDX_W-1:0]  w_idx_q,   w_idx_d;
  logic [7:0]        w_len_q,   w_len_d;
  logic [7:0]        w_cnt_q,   w_cnt_d;
  logic              w_fixed_q, w_fixed_d;
  logic              w_err_q,   w_err_d;
  logic [1:0]        bresp_q,   bresp_d;
  logic              w_last_beat;
  logic              w_lastpos_bad;
  logic              mem_we;

  // Read channel state
  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   rid_q,     rid_d;
  logic [IDX_W-1:0]  r_idx_q,   r_idx_d;
  logic [7:0]        r_len_q,   r_len_d;
  logic [7:0]        r_cnt_q,   r_cnt_d;
  logic              r_fixed_q, r_fixed_d;
  logic              rvalid_q,  rvalid_d;
  logic              rlast_q,   rlast_d;
  logic [AXI_DW-1:0] rdata_q,   rdata_d;
  logic [IDX_W-1:0]  r_next_idx;
  logic [IDX_W-1:0]  r_rd_idx;
  logic [AXI_DW-1:0] mem_rdata;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awsize, s_axi_arsize, s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = (w_state_q == W_IDLE);
  assign s_axi_wready  = (w_state_q == W_DATA);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bid     = w_id_q;
  assign s_axi_bresp   = bresp_q;

  assign s_axi_arready = (r_state_q == R_IDLE);
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = RESP_OKAY;

  assign w_last_beat   = (w_cnt_q == w_len_q);
  assign w_lastpos_bad = (s_axi_wlast != w_last_beat);

  // The burst always runs len+1 beats; a misplaced or missing wlast only taints bresp.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_fixed_d = w_fixed_q;
    w_err_d   = w_err_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid) begin
          w_id_d    = s_axi_awid;
          w_idx_d   = s_axi_awaddr[AXSIZE_WTH +: IDX_W];
          w_len_d   = s_axi_awlen;
          w_fixed_d = (s_axi_awburst == BURST_FIXED);
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          mem_we  = 1'b1;
          w_cnt_d = w_cnt_q + 8'd1;
          w_idx_d = w_fixed_q ? w_idx_q : w_idx_q + 1'b1;
          if (w_lastpos_bad) begin
            w_err_d = 1'b1;
          end
          if (w_last_beat) begin
            bresp_d   = (w_err_q || w_lastpos_bad) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_fixed_q <= w_fixed_d;
      w_err_q   <= w_err_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) begin
          mem[w_idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  // One read port: the AR index while idle, otherwise the following beat's index.
  assign r_next_idx = r_fixed_q ? r_idx_q : r_idx_q + 1'b1;
  assign r_rd_idx   = (r_state_q == R_IDLE) ? s_axi_araddr[AXSIZE_WTH +: IDX_W] : r_next_idx;
  assign mem_rdata  = mem[r_rd_idx];

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_fixed_d = r_fixed_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          rid_d     = s_axi_arid;
          r_idx_d   = r_rd_idx;
          r_len_d   = s_axi_arlen;
          r_fixed_d = (s_axi_arburst == BURST_FIXED);
          r_cnt_d   = '0;
          rdata_d   = mem_rdata;
          rvalid_d  = 1'b1;
          rlast_d   = (s_axi_arlen == 8'd0);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_idx_d = r_next_idx;
            r_cnt_d = r_cnt_q + 8'd1;
            rdata_d = mem_rdata;
            rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_fixed_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_fixed_q <= r_fixed_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_slave_ram.sv
// Self-checking bench for axi_slave_ram: randomized bursts checked against a word-array
// memory model updated per write handshake, plus directed protocol scenarios.
module tb_axi_slave_ram;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  s_axi_awid;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [7:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [7:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [7:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] first_rdata, last_rdata;

  always #5 clk = ~clk;

  axi_slave_ram #(.AXI_DW(32), .AXI_AW(32), .MEM_DEPTH(DEPTH), .ID_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  // Full write transaction; nbeats < len+1 stops after the W beats without waiting for B.
  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [7:0] id, input int wlast_at, input int nbeats,
                          input logic [31:0] data0, input bit rnd_data, input logic [3:0] strb,
                          input bit rnd_strb, input int bready_delay);
    int unsigned idx;
    int n;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  exp_b;
    idx   = (addr >> 2) % DEPTH;
    exp_b = (wlast_at == len) ? 2'b00 : 2'b10;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awsize = 3'd2; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    n = 0;
    while (s_axi_awready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL aw_timeout: awready=%b required 1", s_axi_awready);
      s_axi_awvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    vectors++;
    if (s_axi_awready !== 1'b0) begin
      miscompares++;
      $display("FAIL aw_drop: awready=%b required 0", s_axi_awready);
    end
    for (int b = 0; b < nbeats; b++) begin
      d = rnd_data ? $urandom : data0 + 32'(b);
      s = rnd_strb ? 4'($urandom_range(0, 15)) : strb;
      s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = (b == wlast_at); s_axi_wvalid = 1'b1;
      n = 0;
      while (s_axi_wready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
      vectors++;
      if (n >= 200 || s_axi_bvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL w_beat%0d: wready=%b bvalid=%b required 1/0", b, s_axi_wready, s_axi_bvalid);
        s_axi_wvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) if (s[k]) model_mem[idx][8*k +: 8] = d[8*k +: 8];
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    if (nbeats < len + 1) return;
    vectors++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== exp_b || s_axi_bid !== id) begin
      miscompares++;
      $display("FAIL b_resp: bvalid=%b bresp=%b bid=%h required 1/%b/%h",
               s_axi_bvalid, s_axi_bresp, s_axi_bid, exp_b, id);
    end
    for (int c = 0; c < bready_delay; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0 || s_axi_bresp !== exp_b) begin
        miscompares++;
        $display("FAIL b_hold%0d: bvalid=%b awready=%b bresp=%b required 1/0/%b",
                 c, s_axi_bvalid, s_axi_awready, s_axi_bresp, exp_b);
      end
    end
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    vectors++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
      miscompares++;
      $display("FAIL b_done: bvalid=%b awready=%b required 0/1", s_axi_bvalid, s_axi_awready);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic [7:0] id, input bit toggle);
    int unsigned idx;
    int n, beat;
    bit rr, holding;
    logic [31:0] hold_d;
    logic hold_l;
    idx = (addr >> 2) % DEPTH;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = 3'd2; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    n = 0;
    while (s_axi_arready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL ar_timeout: arready=%b required 1", s_axi_arready);
      s_axi_arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    beat = 0; n = 0; holding = 1'b0; hold_d = '0; hold_l = 1'b0;
    while (beat <= len && n < 2000) begin
      rr = toggle ? (n % 2 == 1) : 1'b1;
      s_axi_rready = rr;
      vectors++;
      if (s_axi_rvalid !== 1'b1) begin
        miscompares++;
        $display("FAIL r_valid beat%0d: rvalid=%b required 1", beat, s_axi_rvalid);
        break;
      end
      if (holding) begin
        vectors++;
        if (s_axi_rdata !== hold_d || s_axi_rlast !== hold_l) begin
          miscompares++;
          $display("FAIL r_stable beat%0d: rdata=%h rlast=%b required %h/%b",
                   beat, s_axi_rdata, s_axi_rlast, hold_d, hold_l);
        end
      end
      vectors++;
      if (s_axi_rdata !== model_mem[idx] || s_axi_rlast !== (beat == len) ||
          s_axi_rid !== id || s_axi_rresp !== 2'b00) begin
        miscompares++;
        $display("FAIL r_beat%0d: rdata=%h rlast=%b rid=%h rresp=%b required %h/%b/%h/00",
                 beat, s_axi_rdata, s_axi_rlast, s_axi_rid, s_axi_rresp,
                 model_mem[idx], (beat == len), id);
      end
      if (beat == 0) first_rdata = s_axi_rdata;
      last_rdata = s_axi_rdata;
      if (rr) begin
        beat++;
        if (burst != 2'b00) idx = (idx + 1) % DEPTH;
        holding = 1'b0;
      end else begin
        holding = 1'b1; hold_d = s_axi_rdata; hold_l = s_axi_rlast;
      end
      @(posedge clk); #1;
      n++;
    end
    s_axi_rready = 1'b0;
    vectors++;
    if (s_axi_rvalid !== 1'b0 || s_axi_rlast !== 1'b0 || s_axi_arready !== 1'b1) begin
      miscompares++;
      $display("FAIL r_end: rvalid=%b rlast=%b arready=%b required 0/0/1",
               s_axi_rvalid, s_axi_rlast, s_axi_arready);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd2; s_axi_awburst = 2'b01;
    s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd2; s_axi_arburst = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast,
         s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid, s_axi_rdata} !== {6'b110000, 52'd0}) begin
      miscompares++;
      $display("FAIL reset: aw/ar/w/b/r/rlast=%b%b%b%b%b%b bresp=%b rresp=%b bid=%h rid=%h rdata=%h required 110000/0/0/0/0/0",
               s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast,
               s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid, s_axi_rdata);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++)
      do_write(32'(i * 1024), 255, 2'b01, 8'(i), 255, 256, '0, 1'b1, 4'hF, 1'b0, 0);
  endtask

  task automatic test_write_read();
    do_write(32'h0, 31, 2'b01, 8'h11, 31, 32, 32'd0, 1'b0, 4'hF, 1'b0, 0);
    do_read(32'h0, 31, 2'b01, 8'h22, 1'b0);
    vectors++;
    if (first_rdata !== 32'd0 || last_rdata !== 32'd31) begin
      miscompares++;
      $display("FAIL write_read_ends: first=%h last=%h required 0/1f", first_rdata, last_rdata);
    end
  endtask

  task automatic test_strobe();
    do_write(32'h40, 0, 2'b01, 8'h01, 0, 1, 32'hAABBCCDD, 1'b0, 4'hF, 1'b0, 0);
    do_write(32'h40, 0, 2'b01, 8'h02, 0, 1, 32'h11223344, 1'b0, 4'b0101, 1'b0, 0);
    do_read(32'h40, 0, 2'b01, 8'h03, 1'b0);
    vectors++;
    if (last_rdata !== 32'hAA22CC44) begin
      miscompares++;
      $display("FAIL strobe: rdata=%h required aa22cc44", last_rdata);
    end
  endtask

  task automatic test_backpressure();
    do_write(32'h100, 7, 2'b01, 8'h33, 7, 8, '0, 1'b1, 4'hF, 1'b0, 5);
    do_read(32'h100, 7, 2'b01, 8'h44, 1'b1);
  endtask

  task automatic test_wrap_fixed();
    do_write(32'(1022 * 4), 3, 2'b01, 8'h55, 3, 4, 32'h9000, 1'b0, 4'hF, 1'b0, 0);
    do_read(32'(1022 * 4), 3, 2'b01, 8'h56, 1'b0);
    do_write(32'h8, 3, 2'b01, 8'h57, 3, 4, 32'h5000, 1'b0, 4'hF, 1'b0, 0);
    do_write(32'h8, 3, 2'b00, 8'h58, 3, 4, 32'h7000, 1'b0, 4'hF, 1'b0, 0);
    do_read(32'h8, 3, 2'b01, 8'h59, 1'b0);
    vectors++;
    if (first_rdata !== 32'h7003 || last_rdata !== 32'h5003) begin
      miscompares++;
      $display("FAIL fixed: word2=%h word5=%h required 7003/5003", first_rdata, last_rdata);
    end
  endtask

  task automatic test_protocol_error();
    do_write(32'h300, 3, 2'b01, 8'h66, 1, 4, 32'hE000, 1'b0, 4'hF, 1'b0, 0);
    do_read(32'h300, 3, 2'b01, 8'h67, 1'b0);
    do_write(32'h380, 2, 2'b01, 8'h68, -1, 3, 32'hE100, 1'b0, 4'hF, 1'b0, 0);
    do_write(32'h3C0, 0, 2'b01, 8'h69, 0, 1, 32'hE200, 1'b0, 4'hF, 1'b0, 0);
  endtask

  task automatic test_same_cycle();
    int unsigned w;
    logic [31:0] old_v, new_v;
    w = 77;
    old_v = model_mem[w];
    new_v = old_v ^ 32'hFFFF_0000;
    s_axi_awid = 8'h03; s_axi_awaddr = 32'(w * 4); s_axi_awlen = 8'd0; s_axi_awburst = 2'b01;
    s_axi_awvalid = 1'b1;
    vectors++;
    if (s_axi_awready !== 1'b1) begin
      miscompares++;
      $display("FAIL same_aw: awready=%b required 1", s_axi_awready);
    end
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    s_axi_wdata = new_v; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_arid = 8'h04; s_axi_araddr = 32'(w * 4); s_axi_arlen = 8'd0; s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b1;
    vectors++;
    if (s_axi_wready !== 1'b1 || s_axi_arready !== 1'b1) begin
      miscompares++;
      $display("FAIL same_ready: wready=%b arready=%b required 1/1", s_axi_wready, s_axi_arready);
    end
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
    model_mem[w] = new_v;
    vectors++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== old_v || s_axi_bvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL same_prewrite: rvalid=%b rdata=%h bvalid=%b required 1/%h/1",
               s_axi_rvalid, s_axi_rdata, s_axi_bvalid, old_v);
    end
    s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    do_read(32'(w * 4), 0, 2'b01, 8'h05, 1'b0);
  endtask

  task automatic test_concurrent();
    fork
      do_write(32'h800, 15, 2'b01, 8'h71, 15, 16, '0, 1'b1, 4'hF, 1'b1, 2);
      do_read(32'h1000, 15, 2'b01, 8'h72, 1'b1);
    join
    do_read(32'h800, 15, 2'b01, 8'h73, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [1:0]  burst;
    int len;
    for (int i = 0; i < 10; i++) begin
      addr  = $urandom;
      len   = $urandom_range(0, 15);
      burst = 2'($urandom_range(0, 2));
      do_write(addr, len, burst, 8'($urandom), len, len + 1, '0, 1'b1, 4'hF, 1'b1,
               $urandom_range(0, 3));
      do_read(addr, len, (burst == 2'b00) ? 2'b01 : burst, 8'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_burst();
    do_write(32'h0, 31, 2'b01, 8'h5A, 31, 10, 32'h1000, 1'b0, 4'hF, 1'b0, 0);
    rstn = 1'b0;
    #2;
    vectors++;
    if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast,
         s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid, s_axi_rdata} !== {6'b110000, 52'd0}) begin
      miscompares++;
      $display("FAIL reset_mid: aw/ar/w/b/r/rlast=%b%b%b%b%b%b bresp=%b bid=%h rdata=%h required 110000/0/0/0",
               s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast,
               s_axi_bresp, s_axi_bid, s_axi_rdata);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    do_read(32'h0, 10, 2'b01, 8'h5B, 1'b0);
    do_write(32'h200, 3, 2'b01, 8'h5C, 3, 4, 32'h2000, 1'b0, 4'hF, 1'b0, 0);
    do_read(32'h200, 3, 2'b01, 8'h5D, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_strobe();
    test_backpressure();
    test_wrap_fixed();
    test_protocol_error();
    test_same_cycle();
    test_concurrent();
    test_random();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
